// File: rtl/vga_sync_gen.sv
// VGA timing generator: 640x480@60 sync, visible-area flag and pixel coordinates.
// Runs on the master clock and advances one pixel per pix_en strobe.
module vga_sync_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int SYNC_POL  = 0
) (
   input  logic       original_clk,
   input  logic       reset,
   input  logic       pix_en,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_tick
);

   localparam logic [9:0] H_MAX =
      10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_MAX =
      10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
   localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic       ACT = (SYNC_POL != 0);

   logic [9:0] hn;
   logic [9:0] vn;
   logic       h_wrap;
   logic       f_wrap;
   logic       hs_n;
   logic       vs_n;
   logic       von_n;

   // Outputs are decoded from the next counts so they line up with pixel_x/y.
   always_comb begin
      h_wrap = (pixel_x == H_MAX);
      f_wrap = h_wrap && (pixel_y == V_MAX);
      hn     = h_wrap ? 10'd0 : pixel_x + 10'd1;
      vn     = pixel_y;
      if (h_wrap) begin
         vn = (pixel_y == V_MAX) ? 10'd0 : pixel_y + 10'd1;
      end
      hs_n  = ((hn >= HS_BEG) && (hn <= HS_END)) ? ACT : ~ACT;
      vs_n  = ((vn >= VS_BEG) && (vn <= VS_END)) ? ACT : ~ACT;
      von_n = (hn < H_VIS) && (vn < V_VIS);
   end

   always_ff @(posedge original_clk) begin
      if (reset) begin
         pixel_x    <= 10'd0;
         pixel_y    <= 10'd0;
         hsync      <= ~ACT;
         vsync      <= ~ACT;
         video_on   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         if (pix_en) begin
            pixel_x    <= hn;
            pixel_y    <= vn;
            hsync      <= hs_n;
            vsync      <= vs_n;
            video_on   <= von_n;
            frame_tick <= f_wrap;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 instance plus a tiny
// active-high instance that wraps whole frames within a short run.
module tb_vga_sync_gen;

   logic original_clk = 1'b0;
   logic reset = 1'b1;
   logic pix_en = 1'b0;

   always #5 original_clk = ~original_clk;

   logic       d_hs, d_vs, d_von, d_ft;
   logic [9:0] d_x, d_y;
   logic       s_hs, s_vs, s_von, s_ft;
   logic [9:0] s_x, s_y;

   vga_sync_gen dut (
      .original_clk(original_clk),
      .reset(reset),
      .pix_en(pix_en),
      .hsync(d_hs),
      .vsync(d_vs),
      .video_on(d_von),
      .pixel_x(d_x),
      .pixel_y(d_y),
      .frame_tick(d_ft)
   );

   vga_sync_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_POL(1)
   ) dut_s (
      .original_clk(original_clk),
      .reset(reset),
      .pix_en(pix_en),
      .hsync(s_hs),
      .vsync(s_vs),
      .video_on(s_von),
      .pixel_x(s_x),
      .pixel_y(s_y),
      .frame_tick(s_ft)
   );

   int n_vec = 0;
   int n_err = 0;

   int hd[2]  = '{640, 8};
   int hf[2]  = '{16, 2};
   int hsw[2] = '{96, 4};
   int hbk[2] = '{48, 2};
   int vd[2]  = '{480, 6};
   int vf[2]  = '{10, 1};
   int vsw[2] = '{2, 2};
   int vbk[2] = '{33, 1};
   int pol[2] = '{0, 1};
   string nm[2] = '{"d", "s"};

   int mx[2];
   int my[2];
   int mft[2];
   int mvalid[2];

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void step(input int i);
      int ht = hd[i] + hf[i] + hsw[i] + hbk[i];
      int vt = vd[i] + vf[i] + vsw[i] + vbk[i];
      if (mx[i] == ht - 1) begin
         mx[i] = 0;
         if (my[i] == vt - 1) begin
            my[i]  = 0;
            mft[i] = 1;
         end else begin
            my[i]++;
         end
      end else begin
         mx[i]++;
      end
   endfunction

   task automatic check_dut(input int i);
      int x, y, hs, vs, von, ft;
      int ehs, evs, evon, hb, vb;
      if (i == 0) begin
         x = int'(d_x); y = int'(d_y); hs = int'(d_hs);
         vs = int'(d_vs); von = int'(d_von); ft = int'(d_ft);
      end else begin
         x = int'(s_x); y = int'(s_y); hs = int'(s_hs);
         vs = int'(s_vs); von = int'(s_von); ft = int'(s_ft);
      end
      hb   = hd[i] + hf[i];
      vb   = vd[i] + vf[i];
      ehs  = (mx[i] >= hb && mx[i] < hb + hsw[i]) ? pol[i] : 1 - pol[i];
      evs  = (my[i] >= vb && my[i] < vb + vsw[i]) ? pol[i] : 1 - pol[i];
      evon = (mvalid[i] != 0 && mx[i] < hd[i] && my[i] < vd[i]) ? 1 : 0;
      check({nm[i], "_x"}, x, mx[i]);
      check({nm[i], "_y"}, y, my[i]);
      check({nm[i], "_hsync"}, hs, ehs);
      check({nm[i], "_vsync"}, vs, evs);
      check({nm[i], "_video_on"}, von, evon);
      check({nm[i], "_frame_tick"}, ft, mft[i]);
   endtask

   task automatic tick(input logic en);
      pix_en = en;
      @(posedge original_clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            mx[i] = 0; my[i] = 0; mft[i] = 0; mvalid[i] = 0;
         end else begin
            mft[i] = 0;
            if (en) begin
               step(i);
               mvalid[i] = 1;
            end
         end
      end
      check_dut(0);
      check_dut(1);
   endtask

   task automatic pix4();
      tick(1'b1);
      repeat (3) tick(1'b0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         mx[i] = 0; my[i] = 0; mft[i] = 0; mvalid[i] = 0;
      end

      // reset held with pix_en toggling
      reset = 1'b1;
      tick(1'b1);
      tick(1'b0);
      tick(1'b1);
      check("rst_hsync", int'(d_hs), 1);
      check("rst_vsync", int'(d_vs), 1);
      check("rst_s_hsync", int'(s_hs), 0);
      reset = 1'b0;
      repeat (3) tick(1'b0);
      check("idle_video_on", int'(d_von), 0);

      // one full line at the nominal strobe rate
      for (int k = 0; k < 800; k++) pix4();
      check("line_y", int'(d_y), 1);
      check("line_x", int'(d_x), 0);

      // stall at pixel_x = 300
      for (int k = 0; k < 300; k++) pix4();
      check("stall_pre_x", int'(d_x), 300);
      repeat (50) tick(1'b0);
      check("stall_x", int'(d_x), 300);
      check("stall_ft", int'(d_ft), 0);

      // frame wrap on the small instance
      for (int k = 0; k < 200 && !(mx[1] == 15 && my[1] == 9); k++)
         pix4();
      check("wrap_pre_x", int'(s_x), 15);
      check("wrap_pre_y", int'(s_y), 9);
      tick(1'b1);
      check("wrap_ft", int'(s_ft), 1);
      check("wrap_x", int'(s_x), 0);
      check("wrap_y", int'(s_y), 0);
      check("wrap_video_on", int'(s_von), 1);
      tick(1'b0);
      check("wrap_ft_drop", int'(s_ft), 0);

      // back-to-back strobes from (0,0)
      reset = 1'b1;
      tick(1'b0);
      reset = 1'b0;
      for (int k = 0; k < 1000; k++) tick(1'b1);
      check("b2b_x", int'(d_x), 200);
      check("b2b_y", int'(d_y), 1);

      // reset in the middle of hsync
      for (int k = 0; k < 500; k++) tick(1'b1);
      check("mid_x", int'(d_x), 700);
      check("mid_hsync", int'(d_hs), 0);
      reset = 1'b1;
      tick(1'b1);
      check("mid_rst_x", int'(d_x), 0);
      check("mid_rst_hsync", int'(d_hs), 1);
      reset = 1'b0;
      tick(1'b0);
      check("resume_hold_x", int'(d_x), 0);
      tick(1'b1);
      check("resume_x", int'(d_x), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
